// File: rtl/coin_conditioner_if.sv
// Coin-conditioner bus: raw coin sensors and vending-FSM state in, clean coin pulses out.
// Optional build macro COIN_STATS_EN adds the coins_total counter output.
interface coin_conditioner_if;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TOTAL_W = 8;

    logic               coin50_raw;
    logic               coin100_raw;
    logic               coin200_raw;
    logic [STATE_W-1:0] fsm_state;
    logic               r50;
    logic               r100;
    logic               r200;
    logic               reject;
    logic               busy;
`ifdef COIN_STATS_EN
    logic [TOTAL_W-1:0] coins_total;

    modport master (
        output coin50_raw, coin100_raw, coin200_raw, fsm_state,
        input  r50, r100, r200, reject, busy, coins_total
    );

    modport slave (
        input  coin50_raw, coin100_raw, coin200_raw, fsm_state,
        output r50, r100, r200, reject, busy, coins_total
    );
`else
    modport master (
        output coin50_raw, coin100_raw, coin200_raw, fsm_state,
        input  r50, r100, r200, reject, busy
    );

    modport slave (
        input  coin50_raw, coin100_raw, coin200_raw, fsm_state,
        output r50, r100, r200, reject, busy
    );
`endif
endinterface

// File: rtl/coin_conditioner.sv
// Coin conditioner: synchronise, debounce and edge-detect three raw coin sensors,
// queue coins in saturating pending counters and release them one at a time
// (with a one-cycle gap) while the vending FSM is in a coin-accepting state.
// Optional build macro COIN_STATS_EN adds the coins_total emitted-coin counter.
module coin_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PEND_MAX        = 3
) (
    input  logic                clk,
    input  logic                rst,
    coin_conditioner_if.slave   bus
);
    localparam int unsigned N_COIN  = 3;
    localparam int unsigned DEB_W   = 8;
    localparam int unsigned PEND_W  = 3;
    localparam int unsigned STATE_W = 4;
`ifdef COIN_STATS_EN
    localparam int unsigned TOTAL_W = 8;
`endif
    localparam logic [STATE_W-1:0] LAST_ACCEPT_STATE = STATE_W'(4);

    typedef enum logic {
        ARB_OPEN,
        ARB_GAP
    } arb_state_t;

    arb_state_t             state;
    arb_state_t             state_d;

    logic [N_COIN-1:0]      raw;
    logic [N_COIN-1:0]      sync1;
    logic [N_COIN-1:0]      sync2;
    logic [N_COIN-1:0]      deb_level;
    logic [N_COIN-1:0]      deb_level_d;
    logic [DEB_W-1:0]       deb_cnt   [N_COIN];
    logic [DEB_W-1:0]       deb_cnt_d [N_COIN];
    logic [N_COIN-1:0]      coin_event;
    logic [PEND_W-1:0]      pend      [N_COIN];
    logic [PEND_W-1:0]      pend_d    [N_COIN];
    logic [N_COIN-1:0]      pend_nz;
    logic [N_COIN-1:0]      accept;
    logic [N_COIN-1:0]      rej;
    logic [N_COIN-1:0]      grant;
    logic                   busy_d;

    // Index 0/1/2 = 50/100/200, which is also the emit priority order.
    assign raw = {bus.coin200_raw, bus.coin100_raw, bus.coin50_raw};

    // Two-flop synchroniser for the asynchronous sensor inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: a new level is taken after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        deb_level_d = deb_level;
        coin_event  = '0;
        for (int i = 0; i < N_COIN; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2[i] != deb_level[i]) begin
                if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level_d[i] = sync2[i];
                    coin_event[i]  = sync2[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Arbiter state register: OPEN may emit, GAP blocks the edge after an emit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_OPEN;
        end else begin
            state <= state_d;
        end
    end

    // Arbiter next state and fixed-priority grant.
    always_comb begin
        state_d = ARB_OPEN;
        grant   = '0;
        for (int i = 0; i < N_COIN; i++) begin
            pend_nz[i] = (pend[i] != '0);
        end
        if ((state == ARB_OPEN) && (bus.fsm_state <= LAST_ACCEPT_STATE)) begin
            if (pend_nz[0]) begin
                grant = 3'b001;
            end else if (pend_nz[1]) begin
                grant = 3'b010;
            end else if (pend_nz[2]) begin
                grant = 3'b100;
            end
        end
        if ((state == ARB_OPEN) && (grant != '0)) begin
            state_d = ARB_GAP;
        end
    end

    // Pending counters: saturate against the pre-edge value, net out same-edge event and emit.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < N_COIN; i++) begin
            accept[i] = coin_event[i] && (pend[i] != PEND_W'(PEND_MAX));
            rej[i]    = coin_event[i] && (pend[i] == PEND_W'(PEND_MAX));
            pend_d[i] = pend[i] + PEND_W'(accept[i]) - PEND_W'(grant[i]);
            busy_d    = busy_d | (pend_d[i] != '0);
        end
    end

    // Debounce/pending state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb_level  <= '1;
            for (int i = 0; i < N_COIN; i++) begin
                deb_cnt[i] <= '0;
                pend[i]    <= '0;
            end
            bus.r50    <= 1'b0;
            bus.r100   <= 1'b0;
            bus.r200   <= 1'b0;
            bus.reject <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            deb_level  <= deb_level_d;
            for (int i = 0; i < N_COIN; i++) begin
                deb_cnt[i] <= deb_cnt_d[i];
                pend[i]    <= pend_d[i];
            end
            bus.r50    <= grant[0];
            bus.r100   <= grant[1];
            bus.r200   <= grant[2];
            bus.reject <= |rej;
            bus.busy   <= busy_d;
        end
    end

`ifdef COIN_STATS_EN
    // Count every emitted coin pulse, wrapping at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.coins_total <= '0;
        end else if (grant != '0) begin
            bus.coins_total <= bus.coins_total + TOTAL_W'(1);
        end
    end
`endif
endmodule
